// File: rtl/instr_encoder.sv
// Field-level instruction request encoder: packs R/I-type requests into 9-bit words
// and writes them sequentially into instruction memory with sticky status flags.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_itype,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_operand,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [8:0]        im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [8:0]        enc;
    logic              illegal;

    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);

    always_comb begin
        enc     = '0;
        illegal = 1'b0;
        if (in_is_itype) begin
            enc     = {1'b1, in_operand[4:0], in_op[2:0]};
            illegal = (in_op[2:0] == 3'b110);
        end else begin
            enc     = {1'b0, in_operand[3:0], in_op[3:0]};
            illegal = in_operand[4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= BASE_C;
            im_we        <= 1'b0;
            im_addr      <= BASE_C;
            im_wdata     <= '0;
            count        <= '0;
            done         <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            im_we <= 1'b0;
            // start wins over a request handshaken in the same cycle
            if (start) begin
                state        <= LOAD;
                ptr          <= BASE_C;
                count        <= '0;
                done         <= 1'b0;
                err_illegal  <= 1'b0;
                err_overflow <= 1'b0;
            end else if (in_ready && in_valid) begin
                if (illegal) begin
                    err_illegal <= 1'b1;
                    state       <= ERR;
                end else if (count == DEPTH_C) begin
                    err_overflow <= 1'b1;
                    state        <= ERR;
                end else begin
                    im_we    <= 1'b1;
                    im_addr  <= ptr;
                    im_wdata <= enc;
                    ptr      <= ptr + ADDR_W'(1);
                    count    <= count + (ADDR_W + 1)'(1);
                    if (in_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// compared against a program-level reference model.
module tb_instr_encoder;

    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 0;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_is_itype, in_last;
    logic [3:0]        in_op;
    logic [4:0]        in_operand;
    logic              in_ready, im_we, busy, done, err_illegal, err_overflow;
    logic [ADDR_W-1:0] im_addr;
    logic [8:0]        im_wdata;
    logic [ADDR_W:0]   count;

    int tests = 0;
    int fails = 0;

    // reference model: loading flag, words written so far, last write, sticky flags
    bit m_load, m_we, m_done, m_ill, m_ovf;
    int m_count, m_addr, m_data;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_itype(in_is_itype), .in_op(in_op), .in_operand(in_operand), .in_last(in_last),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .count(count), .busy(busy),
        .done(done), .err_illegal(err_illegal), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    function automatic int encode(input bit it, input int op, input int opnd);
        if (it) return 256 + (opnd % 32) * 8 + (op % 8);
        return (opnd % 16) * 16 + (op % 16);
    endfunction

    function automatic bit is_illegal(input bit it, input int op, input int opnd);
        return it ? ((op % 8) == 6) : (opnd >= 16);
    endfunction

    // one clock: drive inputs at negedge, advance the model, return 1 time unit after posedge
    task automatic drive(input bit r, input bit s, input bit v, input bit it,
                         input int op, input int opnd, input bit l);
        @(negedge clk);
        reset = r; start = s; in_valid = v; in_is_itype = it;
        in_op = op[3:0]; in_operand = opnd[4:0]; in_last = l;
        if (r) begin
            m_load = 0; m_we = 0; m_done = 0; m_ill = 0; m_ovf = 0;
            m_count = 0; m_addr = BASE_ADDR; m_data = 0;
        end else if (s) begin
            m_load = 1; m_we = 0; m_done = 0; m_ill = 0; m_ovf = 0; m_count = 0;
        end else if (m_load && v) begin
            m_we = 0;
            if (is_illegal(it, op, opnd)) begin
                m_ill = 1; m_load = 0;
            end else if (m_count == DEPTH) begin
                m_ovf = 1; m_load = 0;
            end else begin
                m_we = 1; m_addr = BASE_ADDR + m_count; m_data = encode(it, op, opnd);
                m_count++;
                if (l) begin m_done = 1; m_load = 0; end
            end
        end else begin
            m_we = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input bit it, input int op, input int opnd, input bit l);
        drive(0, 0, 1, it, op, opnd, l);
    endtask

    task automatic do_start();
        drive(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 5, 9, 1);
        tests++;
        if ({im_we, im_addr, im_wdata, count, busy, done, err_illegal, err_overflow, in_ready}
            !== {1'b0, 8'(BASE_ADDR), 9'h000, 9'd0, 5'b00000}) begin
            fails++;
            $display("FAIL reset_state: got we=%0b addr=%h data=%h count=%0d busy=%0b done=%0b ill=%0b ovf=%0b rdy=%0b, want all zero/base",
                     im_we, im_addr, im_wdata, count, busy, done, err_illegal, err_overflow, in_ready);
        end
        idle();
    endtask

    task automatic test_basic();
        do_start();
        tests++;
        if ({busy, in_ready, count} !== {1'b1, 1'b1, 9'd0}) begin
            fails++; $display("FAIL start_load: got busy=%0b rdy=%0b count=%0d, want 1/1/0", busy, in_ready, count);
        end
        send(1, 0, 5, 0);
        tests++;
        if ({im_we, im_addr, im_wdata} !== {1'b1, 8'h00, 9'h128}) begin
            fails++; $display("FAIL basic_w0: got we=%0b addr=%h data=%h, want 1/00/128", im_we, im_addr, im_wdata);
        end
        send(0, 8, 3, 1);
        tests++;
        if ({im_we, im_addr, im_wdata, done, count, busy} !== {1'b1, 8'h01, 9'h038, 1'b1, 9'd2, 1'b0}) begin
            fails++; $display("FAIL basic_w1: got we=%0b addr=%h data=%h done=%0b count=%0d busy=%0b, want 1/01/038/1/2/0",
                              im_we, im_addr, im_wdata, done, count, busy);
        end
        idle();
        tests++;
        if ({im_we, in_ready, done} !== 3'b001) begin
            fails++; $display("FAIL done_hold: got we=%0b rdy=%0b done=%0b, want 0/0/1", im_we, in_ready, done);
        end
    endtask

    task automatic test_gaps();
        do_start();
        send(0, 9, 2, 0);
        tests++;
        if ({im_we, im_addr, im_wdata} !== {1'b1, 8'h00, 9'h029}) begin
            fails++; $display("FAIL gaps_w0: got we=%0b addr=%h data=%h, want 1/00/029", im_we, im_addr, im_wdata);
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            tests++;
            if ({im_we, busy} !== 2'b01) begin
                fails++; $display("FAIL gaps_idle: got we=%0b busy=%0b, want 0/1", im_we, busy);
            end
        end
        send(1, 7, 31, 1);
        tests++;
        if ({im_we, im_addr, im_wdata, done} !== {1'b1, 8'h01, 9'h1FF, 1'b1}) begin
            fails++; $display("FAIL gaps_w1: got we=%0b addr=%h data=%h done=%0b, want 1/01/1FF/1", im_we, im_addr, im_wdata, done);
        end
    endtask

    task automatic test_illegal();
        do_start();
        send(1, 6, 4, 0);
        tests++;
        if ({im_we, err_illegal, busy, in_ready, done} !== 5'b01000) begin
            fails++; $display("FAIL illegal_itype: got we=%0b ill=%0b busy=%0b rdy=%0b done=%0b, want 0/1/0/0/0",
                              im_we, err_illegal, busy, in_ready, done);
        end
        do_start();
        tests++;
        if ({err_illegal, err_overflow, busy, in_ready} !== 4'b0011) begin
            fails++; $display("FAIL illegal_restart: got ill=%0b ovf=%0b busy=%0b rdy=%0b, want 0/0/1/1",
                              err_illegal, err_overflow, busy, in_ready);
        end
        send(0, 3, 16, 1);
        tests++;
        if ({im_we, err_illegal, done, count} !== {3'b010, 9'd0}) begin
            fails++; $display("FAIL illegal_rtype_last: got we=%0b ill=%0b done=%0b count=%0d, want 0/1/0/0",
                              im_we, err_illegal, done, count);
        end
    endtask

    task automatic test_overflow();
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            send(0, i, i + 1, 0);
            tests++;
            if ({im_we, im_addr, im_wdata} !== {1'b1, 8'(BASE_ADDR + i), 9'(encode(0, i, i + 1))}) begin
                fails++; $display("FAIL ovf_write%0d: got we=%0b addr=%h data=%h", i, im_we, im_addr, im_wdata);
            end
        end
        send(1, 1, 1, 0);
        tests++;
        if ({im_we, err_overflow, err_illegal, count, busy} !== {3'b010, 9'(DEPTH), 1'b0}) begin
            fails++; $display("FAIL overflow: got we=%0b ovf=%0b ill=%0b count=%0d busy=%0b, want 0/1/0/%0d/0",
                              im_we, err_overflow, err_illegal, count, busy, DEPTH);
        end
        do_start();
        for (int i = 0; i < DEPTH; i++) send(1, 2, i, i == DEPTH - 1);
        tests++;
        if ({im_we, im_addr, done, err_overflow} !== {1'b1, 8'(BASE_ADDR + DEPTH - 1), 2'b10}) begin
            fails++; $display("FAIL boundary_done: got we=%0b addr=%h done=%0b ovf=%0b, want 1/%h/1/0",
                              im_we, im_addr, done, err_overflow, BASE_ADDR + DEPTH - 1);
        end
    endtask

    task automatic test_restart();
        do_start();
        send(0, 1, 1, 0);
        send(0, 2, 2, 0);
        drive(0, 1, 1, 0, 5, 5, 0);
        tests++;
        if ({im_we, count, busy} !== {1'b0, 9'd0, 1'b1}) begin
            fails++; $display("FAIL restart_discard: got we=%0b count=%0d busy=%0b, want 0/0/1", im_we, count, busy);
        end
        send(0, 4, 6, 0);
        tests++;
        if ({im_we, im_addr, im_wdata, count} !== {1'b1, 8'(BASE_ADDR), 9'h064, 9'd1}) begin
            fails++; $display("FAIL restart_first: got we=%0b addr=%h data=%h count=%0d, want 1/00/064/1",
                              im_we, im_addr, im_wdata, count);
        end
    endtask

    task automatic test_reset_midload();
        do_start();
        for (int i = 0; i < 3; i++) send(0, i, i, 0);
        drive(1, 0, 1, 0, 7, 7, 0);
        tests++;
        if ({im_we, im_addr, im_wdata, count, busy, done, err_illegal, err_overflow, in_ready}
            !== {1'b0, 8'(BASE_ADDR), 9'h000, 9'd0, 5'b00000}) begin
            fails++; $display("FAIL reset_midload: got we=%0b addr=%h data=%h count=%0d busy=%0b rdy=%0b",
                              im_we, im_addr, im_wdata, count, busy, in_ready);
        end
        send(0, 7, 7, 0);
        tests++;
        if ({im_we, count, busy} !== {1'b0, 9'd0, 1'b0}) begin
            fails++; $display("FAIL post_reset_ignore: got we=%0b count=%0d busy=%0b, want 0/0/0", im_we, count, busy);
        end
    endtask

    task automatic test_random();
        bit [31:0] got, want;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
                  $urandom_range(1) == 1, $urandom_range(15), $urandom_range(31),
                  $urandom_range(5) == 0);
            got  = {im_we, im_addr, im_wdata, count, busy, done, err_illegal, err_overflow, in_ready};
            want = {m_we, 8'(m_addr), 9'(m_data), 9'(m_count), m_load, m_done, m_ill, m_ovf, m_load};
            tests++;
            if (got !== want) begin
                fails++; $display("FAIL random_cycle%0d: got %h want %h", n, got, want);
            end
        end
    endtask

    initial begin
        reset = 1; start = 0; in_valid = 0; in_is_itype = 0; in_op = 0; in_operand = 0; in_last = 0;
        m_load = 0; m_we = 0; m_done = 0; m_ill = 0; m_ovf = 0;
        m_count = 0; m_addr = BASE_ADDR; m_data = 0;
        test_reset();
        test_basic();
        test_gaps();
        test_illegal();
        test_overflow();
        test_restart();
        test_reset_midload();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Encodes field-level instruction requests (type, opcode, operand) into the 9-bit machine-instruction format consumed by the control decoder. It writes each encoded word sequentially into instruction memory. It sits between the test/boot loader and instruction memory, and is the producer end of the decoder's instruction interface. It uses a valid/ready input handshake, an address counter, and sticky error reporting.

Parameters:
ADDR_W, 8, instruction-memory address width
DEPTH, 256, number of writable words (must be ≤ 2^ADDR_W; BASE_ADDR+DEPTH ≤ 2^ADDR_W)
BASE_ADDR, 0, first address written after start

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins or restarts a program load
in_valid  input  1  request present
in_ready  output  1  block accepts request this cycle
in_is_itype  input  1  1 = I-type, 0 = R-type
in_op  input  4  opcode; R-type uses [3:0], I-type uses [2:0] ([3] ignored)
in_operand  input  5  I-type 5-bit immediate; R-type register index in [3:0]
in_last  input  1  marks final instruction of program
im_we  output  1  instruction-memory write enable
im_addr  output  ADDR_W  write address
im_wdata  output  9  encoded instruction
count  output  ADDR_W+1  number of words written since start
busy  output  1  state == LOAD
done  output  1  sticky; program loaded cleanly
err_illegal  output  1  sticky; illegal request rejected
err_overflow  output  1  sticky; request beyond DEPTH rejected

Behaviour:
- Encoding:
  - R-type: im_wdata = {1'b0, in_operand[3:0], in_op[3:0]}.
  - I-type: im_wdata = {1'b1, in_operand[4:0], in_op[2:0]}.
- Illegal requests:
  - I-type with in_op[2:0] == 3'b110 (unassigned).
  - R-type with in_operand[4] == 1.
- FSM states: IDLE, LOAD, DONE, ERR.
- Reset (any state, including mid-load): state=IDLE. im_we=0, im_addr=BASE_ADDR, im_wdata=0, count=0, busy=0, done=0, err_illegal=0, err_overflow=0, in_ready=0.
- IDLE/DONE/ERR: in_ready=0; outputs hold.
  - start → LOAD next cycle.
  - On that start: count=0, write pointer=BASE_ADDR, done/err flags cleared.
- LOAD: in_ready=1 combinationally from state. Handshake = in_valid & in_ready.
  - Legal handshake with count < DEPTH:
    - Next cycle: im_we=1, im_addr=pointer, im_wdata=encoded word (1-cycle latency, registered outputs).
    - Then pointer+1 and count+1.
    - If in_last, → DONE and done=1, both in the same cycle as im_we.
  - Illegal handshake: no write; err_illegal=1; → ERR.
  - Handshake with count == DEPTH: no write; err_overflow=1; → ERR. Illegal takes priority over overflow if both apply.
  - No handshake: im_we=0.
- im_we is a single-cycle pulse per accepted legal word. Back-to-back handshakes give back-to-back writes at consecutive addresses.
- start during LOAD: restarts the load.
  - A request handshaken in the same cycle is discarded (start has priority).
  - im_we=0 next cycle; pointer=BASE_ADDR; count=0.
- Boundary: a write to address BASE_ADDR+DEPTH-1 with in_last is a clean DONE. Pointer never wraps; overflow is flagged instead.
- in_last on an illegal request → ERR, not DONE.

Test Plan:
1. Reset, start; send ADDI imm=5 (I, op=0, operand=5) then LW reg 3 (R, op=8, operand=3, last) back-to-back → im_we pulses on two consecutive cycles: addr 0 data 9'h128, then addr 1 data 9'h038. done=1, count=2, busy=0.
2. Start; send SW reg 2 (R, op=9, operand=2) with in_valid gaps of 2 cycles, then LUTA imm=31 (I, op=7, operand=31, last) → writes addr 0 9'h029, addr 1 9'h1FF. No im_we during gaps.
3. Start; send I-type op=6 → no write, err_illegal=1, state ERR, in_ready=0. Then start → flags clear, busy=1.
4. DEPTH=4: start; 4 legal non-last words, then a 5th → 4 writes at addr 0..3; 5th rejected; err_overflow=1, count=4.
5. Start; write 2 words; assert start together with a valid request → that request is not written, count=0. The next word is written at BASE_ADDR.
6. Assert reset mid-load after 3 writes → all outputs at reset values next cycle. A following handshake is ignored until start.
